// File: rtl/overcurrent_retry_ctrl.sv
// Overcurrent trip / retry / lockout sequencer for one H-Bridge channel.
// A clocked, debounced FSM gates the H-Bridge enable around the overcurrent comparators.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   pwm_in        PWM from the PWM generator (already synchronous)
//   over_in       async comparator: current above upper threshold
//   under_in      async comparator: current below lower threshold
//   clear         single-cycle pulse that releases LOCKOUT
//   en_out        registered H-Bridge enable
//   motor_out     H-Bridge input, pwm_in gated by en_out
//   fault_latched registered, 1 while in LOCKOUT
//   fault_cnt     trips since the last clean period or reset
//   state         RUN=0, TRIP=1, COOL=2, LOCKOUT=3
module overcurrent_retry_ctrl #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned COOL_CYCLES  = 50000,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned CLEAN_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  input  logic       over_in,
  input  logic       under_in,
  input  logic       clear,
  output logic       en_out,
  output logic       motor_out,
  output logic       fault_latched,
  output logic [2:0] fault_cnt,
  output logic [1:0] state
);

  localparam int unsigned DebW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned CoolW  = $clog2(COOL_CYCLES + 1);
  localparam int unsigned CleanW = $clog2(CLEAN_CYCLES + 1);

  localparam logic [DebW-1:0]   DebMax     = DebW'(DEB_CYCLES);
  localparam logic [DebW-1:0]   DebLast    = DebW'(DEB_CYCLES - 1);
  localparam logic [CoolW-1:0]  CoolLoad   = CoolW'(COOL_CYCLES - 1);
  localparam logic [CleanW-1:0] CleanLast  = CleanW'(CLEAN_CYCLES - 1);
  localparam logic [2:0]        MaxRetries = 3'(MAX_RETRIES);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StTrip    = 2'd1,
    StCool    = 2'd2,
    StLockout = 2'd3
  } state_e;

  state_e             state_q;
  logic               en_q;
  logic               fault_latched_q;
  logic [2:0]         fault_cnt_q;
  logic               over_meta_q, over_s_q;
  logic               under_meta_q, under_s_q;
  logic [DebW-1:0]    deb_q;
  logic [CoolW-1:0]   cool_q;
  logic [CleanW-1:0]  clean_q;

  logic trip;
  logic release_ok;
  logic lockout_hit;

  // Trip fires on the edge where the debounce count reaches DEB_CYCLES, so the
  // enable drops on that same edge rather than one cycle later.
  assign trip        = over_s_q && (deb_q >= DebLast);
  assign release_ok  = !over_s_q && under_s_q;
  assign lockout_hit = (fault_cnt_q == MaxRetries);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StRun;
      en_q            <= 1'b1;
      fault_latched_q <= 1'b0;
      fault_cnt_q     <= '0;
      over_meta_q     <= 1'b0;
      over_s_q        <= 1'b0;
      under_meta_q    <= 1'b0;
      under_s_q       <= 1'b0;
      deb_q           <= '0;
      cool_q          <= '0;
      clean_q         <= '0;
    end else begin
      over_meta_q  <= over_in;
      over_s_q     <= over_meta_q;
      under_meta_q <= under_in;
      under_s_q    <= under_meta_q;

      if (!over_s_q) begin
        deb_q <= '0;
      end else if (deb_q != DebMax) begin
        deb_q <= deb_q + 1'b1;
      end

      unique case (state_q)
        StRun, StCool: begin
          if (trip) begin
            // A trip while cooling is handled exactly like a trip in RUN and
            // wins over cooldown expiry.
            state_q         <= lockout_hit ? StLockout : StTrip;
            fault_cnt_q     <= lockout_hit ? fault_cnt_q : fault_cnt_q + 3'd1;
            fault_latched_q <= lockout_hit;
            en_q            <= 1'b0;
            clean_q         <= '0;
          end else if (state_q == StRun) begin
            if (clean_q == CleanLast) begin
              clean_q     <= '0;
              fault_cnt_q <= '0;
            end else begin
              clean_q <= clean_q + 1'b1;
            end
          end else if (cool_q == '0) begin
            state_q <= StRun;
            en_q    <= 1'b1;
          end else begin
            cool_q <= cool_q - 1'b1;
          end
        end
        StTrip: begin
          if (release_ok) begin
            cool_q  <= CoolLoad;
            state_q <= StCool;
          end
        end
        StLockout: begin
          // clear is acted on only when the current is back in the window.
          if (clear && release_ok) begin
            fault_cnt_q     <= '0;
            fault_latched_q <= 1'b0;
            cool_q          <= CoolLoad;
            state_q         <= StCool;
          end
        end
      endcase
    end
  end

  assign en_out        = en_q;
  assign motor_out     = pwm_in & en_q;
  assign fault_latched = fault_latched_q;
  assign fault_cnt     = fault_cnt_q;
  assign state         = state_q;

endmodule
